// File: rtl/uart_pkg.sv
// Shared types and helpers for the AXI-Stream UART TX arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_HDR,
    ARB_XFER
  } uart_arb_state_t;

  localparam int unsigned ARB_MAX_CH = 16;

  // Round-robin successor of idx among n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] idx
);

  always_comb begin
    int unsigned k;
    logic        found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      k = 32'(ptr) + i;
      if (k >= N) k = k - N;
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = k[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/axis_uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX AXI-Stream among NUM_CH sources.
// Define AXIS_UART_ARB_HDR_EN to prefix each grant with a channel-index header byte.
module axis_uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_tdata_i,
  input  logic [NUM_CH-1:0]            s_tvalid_i,
  input  logic [NUM_CH-1:0]            s_tlast_i,
  output logic [NUM_CH-1:0]            s_tready_o,
  output logic [DATA_WIDTH-1:0]        m_tdata_o,
  output logic                         m_tvalid_o,
  output logic                         m_tlast_o,
  input  logic                         m_tready_i,
  output logic [NUM_CH-1:0]            grant_o,
  output logic                         burst_cut_o
);

  localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] CapVal = CntW'(MAX_BURST - 1);

  uart_arb_state_t   state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   gidx_q, gidx_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [NUM_CH-1:0] pick_gnt;
  logic [IdxW-1:0]   pick_idx;

  logic              g_valid;
  logic              g_last;
  logic              g_hs;
  logic              at_cap;

  rr_arbiter #(
    .N    (NUM_CH),
    .IdxW (IdxW)
  ) u_rr (
    .req (s_tvalid_i),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign grant_o = grant_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    s_tready_o  = '0;
    m_tdata_o   = '0;
    m_tvalid_o  = 1'b0;
    m_tlast_o   = 1'b0;
    burst_cut_o = 1'b0;
    g_valid     = 1'b0;
    g_last      = 1'b0;
    g_hs        = 1'b0;
    at_cap      = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (|s_tvalid_i) begin
          gidx_d  = pick_idx;
          grant_d = pick_gnt;
          ptr_d   = IdxW'(rr_next(32'(pick_idx), NUM_CH));
          cnt_d   = '0;
`ifdef AXIS_UART_ARB_HDR_EN
          state_d = ARB_HDR;
`else
          state_d = ARB_XFER;
`endif
        end
      end

`ifdef AXIS_UART_ARB_HDR_EN
      ARB_HDR: begin
        m_tvalid_o = 1'b1;
        m_tdata_o  = DATA_WIDTH'(gidx_q);
        if (m_tready_i) state_d = ARB_XFER;
      end
`endif

      ARB_XFER: begin
        g_valid                = s_tvalid_i[gidx_q];
        g_last                 = s_tlast_i[gidx_q];
        at_cap                 = (cnt_q == CapVal);
        g_hs                   = g_valid && m_tready_i;
        m_tdata_o              = s_tdata_i[gidx_q*DATA_WIDTH +: DATA_WIDTH];
        m_tvalid_o             = g_valid;
        m_tlast_o              = g_last || at_cap;
        s_tready_o[gidx_q]     = m_tready_i;
        if (g_hs) begin
          if (g_last || at_cap) begin
            state_d     = ARB_IDLE;
            cnt_d       = '0;
            grant_d     = '0;
            // tlast on the cap beat is a normal release, not a forced one
            burst_cut_o = !g_last;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end

      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
